// File: rtl/alu_serial_ctrl_if.sv
// Bundle of the request/response and ALU-slice signals of the bit-serial sequencer.
// The slave modport is the sequencer; the master side issues requests and hosts the slice.
interface alu_serial_ctrl_if #(
    parameter int unsigned WIDTH = 128
);
    logic             start;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             cin;
    logic [2:0]       opsel;
    logic             mode;

    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_flag;
    logic             z_flag;
    logic             o_flag;
    logic             s_flag;

    logic             slice_op1;
    logic             slice_op2;
    logic             slice_cin;
    logic [2:0]       slice_opsel;
    logic             slice_mode;
    logic             slice_result;
    logic             slice_cout;

    modport master (
        output start, op1, op2, cin, opsel, mode, slice_result, slice_cout,
        input  busy, done, result, c_flag, z_flag, o_flag, s_flag,
               slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode
    );

    modport slave (
        input  start, op1, op2, cin, opsel, mode, slice_result, slice_cout,
        output busy, done, result, c_flag, z_flag, o_flag, s_flag,
               slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: walks a 1-bit ALU slice LSB-first over WIDTH bits,
// chaining carry, assembling the result and producing C/Z/O/S flags plus a done pulse.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 128
) (
    input logic              clk,
    input logic              rst,
    alu_serial_ctrl_if.slave bus
);
    localparam int unsigned IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [2:0]       opsel_q;
    logic             mode_q;

    logic             run;
    logic [WIDTH-1:0] acc_next;
    logic             carry_next;

    // Operands shift right so bit[index] is always at position 0; result fills from the MSB.
    assign run        = (state == RUN);
    assign acc_next   = {bus.slice_result, acc[WIDTH-1:1]};
    assign carry_next = ~mode_q & bus.slice_cout;

    assign bus.slice_op1   = run & a_sr[0];
    assign bus.slice_op2   = run & b_sr[0];
    assign bus.slice_cin   = run & carry;
    assign bus.slice_opsel = run ? opsel_q : '0;
    assign bus.slice_mode  = run & mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            acc        <= '0;
            idx        <= '0;
            carry      <= 1'b0;
            opsel_q    <= '0;
            mode_q     <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.c_flag <= 1'b0;
            bus.z_flag <= 1'b0;
            bus.o_flag <= 1'b0;
            bus.s_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr     <= bus.op1;
                        b_sr     <= bus.op2;
                        acc      <= '0;
                        opsel_q  <= bus.opsel;
                        mode_q   <= bus.mode;
                        idx      <= '0;
                        carry    <= ~bus.mode & bus.cin;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= carry_next;
                    if (idx == IW'(WIDTH - 1)) begin
                        // carry still holds the carry into the MSB here, so overflow is formed directly
                        bus.result <= acc_next;
                        bus.c_flag <= carry_next;
                        bus.o_flag <= ~mode_q & (carry ^ bus.slice_cout);
                        bus.z_flag <= (acc_next == '0);
                        bus.s_flag <= bus.slice_result;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: hosts a 1-bit slice model and compares every cycle
// against a whole-word reference of the operation and its cycle timeline.
module tb_alu_serial_ctrl;
    localparam int unsigned W = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Slice: arithmetic mode is a full adder; logic mode picks AND/OR/XOR by opsel (others AND).
    function automatic logic [1:0] slice_fn(input logic a, input logic b, input logic ci,
                                            input logic [2:0] os, input logic md);
        logic r;
        if (!md) return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
        case (os)
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            default: r = a & b;
        endcase
        return {1'b0, r};
    endfunction

    assign {bus.slice_cout, bus.slice_result} =
        slice_fn(bus.slice_op1, bus.slice_op2, bus.slice_cin, bus.slice_opsel, bus.slice_mode);

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word result of the latched operation plus where it sits on the timeline.
    int             m_phase = 0;   // 0 idle, 1..W = bit m_phase-1 in flight, W+1 = done cycle
    logic [W-1:0]   m_a, m_b, m_result;
    logic [W:0]     m_sum;
    logic [2:0]     m_os;
    logic           m_md;
    logic           m_busy, m_done, m_c, m_z, m_o, m_s;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_busy = 0; m_done = 0;
            m_result = '0; m_c = 0; m_z = 0; m_o = 0; m_s = 0;
            m_a = '0; m_b = '0; m_sum = '0; m_os = '0; m_md = 0;
        end else if (m_phase == 0) begin
            if (bus.start) begin
                m_a = bus.op1; m_b = bus.op2; m_os = bus.opsel; m_md = bus.mode;
                m_sum = {1'b0, bus.op1} + {1'b0, bus.op2} + {{W{1'b0}}, bus.cin & ~bus.mode};
                m_phase = 1; m_busy = 1;
            end
        end else if (m_phase < int'(W)) begin
            m_phase++;
        end else if (m_phase == int'(W)) begin
            if (!m_md) begin
                m_result = m_sum[W-1:0];
                m_c = m_sum[W];
                m_o = (m_a[W-1] == m_b[W-1]) && (m_result[W-1] != m_a[W-1]);
            end else begin
                case (m_os)
                    3'd1:    m_result = m_a | m_b;
                    3'd2:    m_result = m_a ^ m_b;
                    default: m_result = m_a & m_b;
                endcase
                m_c = 0; m_o = 0;
            end
            m_z = (m_result == '0);
            m_s = m_result[W-1];
            m_phase = W + 1; m_busy = 0; m_done = 1;
        end else begin
            m_phase = 0; m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", W'(bus.busy), W'(m_busy));
            chk("done", W'(bus.done), W'(m_done));
            chk("result", bus.result, m_result);
            chk("c_flag", W'(bus.c_flag), W'(m_c));
            chk("z_flag", W'(bus.z_flag), W'(m_z));
            chk("o_flag", W'(bus.o_flag), W'(m_o));
            chk("s_flag", W'(bus.s_flag), W'(m_s));
            if (m_phase >= 1 && m_phase <= int'(W)) begin
                int k;
                k = m_phase - 1;
                chk("slice_op1", W'(bus.slice_op1), W'(m_a[k]));
                chk("slice_op2", W'(bus.slice_op2), W'(m_b[k]));
                chk("slice_cin", W'(bus.slice_cin), W'(~m_md & (m_sum[k] ^ m_a[k] ^ m_b[k])));
                chk("slice_opsel", W'(bus.slice_opsel), W'(m_os));
                chk("slice_mode", W'(bus.slice_mode), W'(m_md));
            end else if (m_phase == 0) begin
                chk("slice_idle", W'({bus.slice_op1, bus.slice_op2, bus.slice_cin,
                                      bus.slice_opsel, bus.slice_mode}), '0);
            end
        end
    end

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic scramble();
        bus.op1 = rnd_word(); bus.op2 = rnd_word(); bus.cin = 1'($urandom);
        bus.opsel = 3'($urandom); bus.mode = 1'($urandom);
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                            input logic [2:0] os, input logic md);
        @(posedge clk); #2;
        bus.start = 1; bus.op1 = a; bus.op2 = b; bus.cin = ci; bus.opsel = os; bus.mode = md;
        @(posedge clk); #2;
        bus.start = 0;
        scramble();
    endtask

    task automatic wait_done(input string tag, output int busy_cycles);
        bit got;
        got = 0; busy_cycles = 0;
        for (int i = 0; i < int'(W) + 8 && !got; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
            if (bus.done) got = 1;
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s: no done pulse within %0d cycles", tag, W + 8);
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
    endtask

    task automatic chk_flags(input string tag, input logic [W-1:0] r,
                             input logic c, input logic z, input logic o, input logic s);
        chk({tag, ".result"}, bus.result, r);
        chk({tag, ".cz os"}, W'({bus.c_flag, bus.z_flag, bus.o_flag, bus.s_flag}), W'({c, z, o, s}));
    endtask

    initial begin
        logic [W-1:0] ones, msb, a, b;
        int bc, nd;
        ones = '1;
        msb = '0; msb[W-1] = 1'b1;
        bus.start = 0; bus.op1 = '0; bus.op2 = '0; bus.cin = 0; bus.opsel = '0; bus.mode = 0;

        @(posedge clk); #1; chk_en = 1;
        @(posedge clk); #2; rst = 0;
        @(negedge clk);
        chk_flags("reset", '0, 0, 0, 0, 0);
        chk("reset.busy_done", W'({bus.busy, bus.done}), '0);

        // 1: plain add, exact busy length
        start_op(W'(5), W'(3), 0, 3'd0, 0);
        wait_done("add", bc);
        chk("add.busy_cycles", W'(bc), W'(W));
        chk_flags("add", W'(8), 0, 0, 0, 0);

        // 2: carry out with zero result
        start_op(ones, W'(1), 0, 3'd0, 0);
        wait_done("carry", bc);
        chk_flags("carry", '0, 1, 1, 0, 0);

        // 3: signed overflow both directions
        start_op(~msb, W'(1), 0, 3'd0, 0);
        wait_done("ovf_pos", bc);
        chk_flags("ovf_pos", msb, 0, 0, 1, 1);
        start_op(msb, msb, 0, 3'd0, 0);
        wait_done("ovf_neg", bc);
        chk_flags("ovf_neg", '0, 1, 1, 1, 0);

        // 4: logic AND, cin must not leak into the chain
        start_op({16{8'hF0}}, {{8{8'hFF}}, {8{8'h00}}}, 1, 3'd0, 1);
        wait_done("logic", bc);
        chk_flags("logic", {{8{8'hF0}}, 64'h0}, 0, 0, 0, 1);

        // 5: starts during RUN and DONE are dropped
        start_op(W'(100), W'(23), 1, 3'd0, 0);
        repeat (8) @(posedge clk);
        #2; bus.start = 1; bus.op1 = W'(7); bus.op2 = W'(9);
        @(posedge clk); #2; bus.start = 0;
        wait_done("ignore", bc);
        bus.start = 1; bus.op1 = W'(55); bus.op2 = W'(66);
        @(posedge clk); #2; bus.start = 0;
        chk_flags("ignore", W'(124), 0, 0, 0, 0);
        count_done(W + 4, nd);
        chk("ignore.extra_done", W'(nd), '0);

        // 6: reset mid-run, then a clean operation
        start_op(ones, ones, 1, 3'd0, 0);
        repeat (49) @(posedge clk);
        #2; rst = 1;
        @(posedge clk); #2; rst = 0;
        chk_flags("midrst", '0, 0, 0, 0, 0);
        chk("midrst.busy_done", W'({bus.busy, bus.done}), '0);
        count_done(W + 4, nd);
        chk("midrst.no_done", W'(nd), '0);
        start_op(W'(1000), W'(24), 0, 3'd0, 0);
        wait_done("postrst", bc);
        chk_flags("postrst", W'(1024), 0, 0, 0, 0);

        // Randomised operations; the per-cycle compare does the checking
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0: begin a = ones; b = rnd_word(); end
                1: begin a = msb; b = msb ^ rnd_word(); end
                default: begin a = rnd_word(); b = rnd_word(); end
            endcase
            start_op(a, b, 1'($urandom), 3'($urandom), 1'($urandom));
            wait_done("random", bc);
            chk("random.busy_cycles", W'(bc), W'(W));
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
